// File: rtl/ws_rx_pkg.sv
// Shared constants and FSM encoding for the WS2812B pixel receiver.
// Default timing values assume the 96 MHz PLL clock.
package ws_rx_pkg;

  localparam int unsigned T0H_CLKS   = 38;
  localparam int unsigned T1H_CLKS   = 77;
  localparam int unsigned TBIT_CLKS  = 120;
  localparam int unsigned RESET_CLKS = 4800;

  localparam int unsigned PIXEL_GRB  = 24;
  localparam int unsigned PIXEL_GRBW = 32;

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    LOW      = 2'd1,
    HIGH     = 2'd2
  } rx_state_e;

endpackage

// File: rtl/ws_pixel_rx_if.sv
// Pixel valid/ready handshake between the WS2812B receiver and its consumer.
// The receiver drives the payload; the consumer drives pixel_ready.
interface ws_pixel_rx_if
  import ws_rx_pkg::*;
#(
  parameter int unsigned PIXEL_BITS = PIXEL_GRB,
  parameter int unsigned IDX_W      = 10
);
  logic                  pixel_valid;
  logic                  pixel_ready;
  logic [PIXEL_BITS-1:0] pixel_data;
  logic [IDX_W-1:0]      pixel_idx;

  modport master (
    output pixel_valid,
    output pixel_data,
    output pixel_idx,
    input  pixel_ready
  );

  modport slave (
    input  pixel_valid,
    input  pixel_data,
    input  pixel_idx,
    output pixel_ready
  );
endinterface

// File: rtl/ws_edge_sync.sv
// Synchroniser for the asynchronous serial input plus rise/fall strobes on the synchronised level.
// The chain is reset-free so it tracks the line through reset; the receiver FSM masks stale pulses.
module ws_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic i_sig,
  output logic o_level,
  output logic o_rise_c,
  output logic o_fall_c
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk) begin
    r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
    r_prev <= r_sync[SYNC_STAGES-1];
  end

  assign o_level  = r_sync[SYNC_STAGES-1];
  assign o_rise_c = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_fall_c = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/ws_pixel_rx.sv
// WS2812B serial decoder: classifies HIGH pulse widths into bits, assembles pixels MSB-first
// and presents them on a valid/ready handshake with index, stream-reset pulse and sticky errors.
module ws_pixel_rx
  import ws_rx_pkg::*;
#(
  parameter int unsigned PIXEL_BITS        = PIXEL_GRB,
  parameter int unsigned MIN_HIGH_CLKS     = 12,
  parameter int unsigned ONE_THRESH_CLKS   = 57,
  parameter int unsigned STREAM_RESET_CLKS = RESET_CLKS,
  parameter int unsigned IDX_W             = 10,
  parameter int unsigned SYNC_STAGES       = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           sig,
  input  logic           clear_err,
  ws_pixel_rx_if.master  px,
  output logic           frame_end,
  output logic           err_overflow,
  output logic           err_partial,
  output logic           err_glitch
);

  localparam int unsigned CW  = $clog2(STREAM_RESET_CLKS + 1);
  localparam int unsigned BCW = $clog2(PIXEL_BITS + 1);
  localparam logic [IDX_W-1:0] IDX_MAX = '1;

  logic w_level;
  logic w_rise;
  logic w_fall;

  rx_state_e r_state;
  rx_state_e w_state_nxt;
  logic      w_pulse_done;
  logic      w_stream_rst;

  logic [CW-1:0]         r_cnt;
  logic [BCW-1:0]        r_bit_cnt;
  logic [PIXEL_BITS-1:0] r_shift;
  logic [IDX_W-1:0]      r_next_idx;
  logic                  r_valid;
  logic [PIXEL_BITS-1:0] r_data;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_frame_end;
  logic                  r_err_overflow;
  logic                  r_err_partial;
  logic                  r_err_glitch;

  logic                  w_at_limit;
  logic                  w_glitch;
  logic                  w_shift;
  logic                  w_bit;
  logic [PIXEL_BITS-1:0] w_shift_nxt;
  logic                  w_complete;
  logic                  w_stall;

  ws_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk      (clk),
    .i_sig    (sig),
    .o_level  (w_level),
    .o_rise_c (w_rise),
    .o_fall_c (w_fall)
  );

  // Counter reaches the stream-reset length on this cycle; only one cycle per stable period.
  assign w_at_limit = !w_rise && !w_fall && (r_cnt == CW'(STREAM_RESET_CLKS - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= WAIT_LOW;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pulse_done = 1'b0;
    w_stream_rst = 1'b0;
    unique case (r_state)
      WAIT_LOW: begin
        if (!w_level) w_state_nxt = LOW;
      end
      LOW: begin
        if (w_rise)          w_state_nxt  = HIGH;
        else if (w_at_limit) w_stream_rst = 1'b1;
      end
      HIGH: begin
        if (w_fall) begin
          w_state_nxt  = LOW;
          w_pulse_done = 1'b1;
        end else if (w_at_limit) begin
          w_state_nxt  = WAIT_LOW;
          w_stream_rst = 1'b1;
        end
      end
      default: w_state_nxt = WAIT_LOW;
    endcase
  end

  // Pulse classification on the falling edge; the counter still holds the HIGH width.
  assign w_glitch    = w_pulse_done && (r_cnt < CW'(MIN_HIGH_CLKS));
  assign w_shift     = w_pulse_done && !w_glitch;
  assign w_bit       = (r_cnt >= CW'(ONE_THRESH_CLKS));
  assign w_shift_nxt = {r_shift[PIXEL_BITS-2:0], w_bit};
  assign w_complete  = w_shift && (r_bit_cnt == BCW'(PIXEL_BITS - 1));
  assign w_stall     = r_valid && !px.pixel_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt          <= '0;
      r_bit_cnt      <= '0;
      r_shift        <= '0;
      r_next_idx     <= '0;
      r_valid        <= 1'b0;
      r_data         <= '0;
      r_idx          <= '0;
      r_frame_end    <= 1'b0;
      r_err_overflow <= 1'b0;
      r_err_partial  <= 1'b0;
      r_err_glitch   <= 1'b0;
    end else begin
      if (w_rise || w_fall)                          r_cnt <= CW'(1);
      else if (r_cnt != CW'(STREAM_RESET_CLKS))      r_cnt <= r_cnt + CW'(1);

      r_frame_end <= w_stream_rst;

      if (w_stream_rst) begin
        r_bit_cnt  <= '0;
        r_shift    <= '0;
        r_next_idx <= '0;
      end else if (w_shift) begin
        r_shift <= w_shift_nxt;
        if (w_complete) begin
          r_bit_cnt <= '0;
          if (r_next_idx != IDX_MAX) r_next_idx <= r_next_idx + IDX_W'(1);
        end else begin
          r_bit_cnt <= r_bit_cnt + BCW'(1);
        end
      end

      // A pixel completing into a stalled slot is dropped; the held pixel stays put.
      if (w_complete && !w_stall) begin
        r_valid <= 1'b1;
        r_data  <= w_shift_nxt;
        r_idx   <= r_next_idx;
      end else if (r_valid && px.pixel_ready) begin
        r_valid <= 1'b0;
      end

      r_err_overflow <= (w_complete && w_stall) || (r_err_overflow && !clear_err);
      r_err_partial  <= (w_stream_rst && (r_bit_cnt != '0)) || (r_err_partial && !clear_err);
      r_err_glitch   <= w_glitch || (r_err_glitch && !clear_err);
    end
  end

  assign px.pixel_valid = r_valid;
  assign px.pixel_data  = r_data;
  assign px.pixel_idx   = r_idx;
  assign frame_end      = r_frame_end;
  assign err_overflow   = r_err_overflow;
  assign err_partial    = r_err_partial;
  assign err_glitch     = r_err_glitch;

endmodule

// File: tb/tb_ws_pixel_rx.sv
// Directed self-checking bench for ws_pixel_rx: decoding, index/stream reset, glitches,
// handshake stall and overflow, partial pixels and mid-pulse reset.
module tb_ws_pixel_rx;
  import ws_rx_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic sig;
  logic clear_err;
  logic frame_end;
  logic err_overflow;
  logic err_partial;
  logic err_glitch;

  int checks = 0;
  int errors = 0;

  logic [23:0] q_data[$];
  logic [9:0]  q_idx[$];
  int          fe_cycles = 0;
  int          fe_base;

  ws_pixel_rx_if #(.PIXEL_BITS(24), .IDX_W(10)) px ();

  ws_pixel_rx #(
    .PIXEL_BITS        (24),
    .MIN_HIGH_CLKS     (12),
    .ONE_THRESH_CLKS   (57),
    .STREAM_RESET_CLKS (RESET_CLKS),
    .IDX_W             (10),
    .SYNC_STAGES       (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sig          (sig),
    .clear_err    (clear_err),
    .px           (px),
    .frame_end    (frame_end),
    .err_overflow (err_overflow),
    .err_partial  (err_partial),
    .err_glitch   (err_glitch)
  );

  always #5 clk = ~clk;

  // Record accepted transfers and frame_end high cycles, sampled mid-cycle.
  always @(negedge clk) begin
    if (px.pixel_valid && px.pixel_ready) begin
      q_data.push_back(px.pixel_data);
      q_idx.push_back(px.pixel_idx);
    end
    if (frame_end) fe_cycles++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_bit(input logic b);
    int h;
    h = b ? T1H_CLKS : T0H_CLKS;
    sig = 1'b1;
    idle(h);
    sig = 1'b0;
    idle(TBIT_CLKS - h);
  endtask

  task automatic send_bits(input logic [23:0] d, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) send_bit(d[i]);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input int pos,
                            input logic [23:0] exp_d, input logic [9:0] exp_i);
    logic [23:0] d;
    logic [9:0]  ix;
    d  = (q_data.size() > pos) ? q_data[pos] : 24'hxxxxxx;
    ix = (q_idx.size() > pos) ? q_idx[pos] : 10'h3ff;
    check({tag, "_data"}, 32'(d), 32'(exp_d));
    check({tag, "_idx"}, 32'(ix), 32'(exp_i));
  endtask

  initial begin
    rst            = 1'b1;
    sig            = 1'b0;
    clear_err      = 1'b0;
    px.pixel_ready = 1'b1;
    idle(5);
    rst = 1'b0;
    check("rst_valid", 32'(px.pixel_valid), 32'd0);
    check("rst_data", 32'(px.pixel_data), 32'd0);
    check("rst_idx", 32'(px.pixel_idx), 32'd0);
    check("rst_errs", 32'({frame_end, err_overflow, err_partial, err_glitch}), 32'd0);
    idle(2);

    // Single pixel with exact valid timing relative to the last falling edge.
    send_bits(24'hA5C30F, 23, 1);
    sig = 1'b1;
    idle(T1H_CLKS);
    sig = 1'b0;
    idle(2);
    check("t1_valid_before", 32'(px.pixel_valid), 32'd0);
    tick();
    check("t1_valid", 32'(px.pixel_valid), 32'd1);
    check("t1_data", 32'(px.pixel_data), 32'hA5C30F);
    check("t1_idx", 32'(px.pixel_idx), 32'd0);
    tick();
    check("t1_valid_drop", 32'(px.pixel_valid), 32'd0);
    idle(TBIT_CLKS - T1H_CLKS - 4);
    check("t1_count", 32'(q_data.size()), 32'd1);
    idle(4900);

    // Index sequence and frame_end timing.
    q_data.delete();
    q_idx.delete();
    fe_base = fe_cycles;
    send_bits(24'h000001, 23, 0);
    send_bits(24'hFFFFFF, 23, 0);
    send_bits(24'h123456, 23, 0);
    idle(4700);
    check("t2_fe_early", 32'(fe_cycles - fe_base), 32'd0);
    idle(200);
    check("t2_fe_once", 32'(fe_cycles - fe_base), 32'd1);
    send_bits(24'h0F0F0F, 23, 0);
    check("t2_count", 32'(q_data.size()), 32'd4);
    check_head("t2_p0", 0, 24'h000001, 10'd0);
    check_head("t2_p1", 1, 24'hFFFFFF, 10'd1);
    check_head("t2_p2", 2, 24'h123456, 10'd2);
    check_head("t2_p3", 3, 24'h0F0F0F, 10'd0);
    idle(4900);

    // Glitch between bits is rejected and flagged.
    q_data.delete();
    q_idx.delete();
    send_bits(24'h00FF00, 23, 12);
    sig = 1'b1;
    idle(5);
    sig = 1'b0;
    idle(60);
    send_bits(24'h00FF00, 11, 0);
    check("t3_count", 32'(q_data.size()), 32'd1);
    check_head("t3_p0", 0, 24'h00FF00, 10'd0);
    check("t3_glitch", 32'(err_glitch), 32'd1);
    check("t3_other_errs", 32'({err_overflow, err_partial}), 32'd0);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("t3_glitch_clr", 32'(err_glitch), 32'd0);
    idle(4900);

    // Stalled handshake: second pixel dropped, first held, index advances.
    q_data.delete();
    q_idx.delete();
    px.pixel_ready = 1'b0;
    send_bits(24'h111111, 23, 0);
    send_bits(24'h222222, 23, 0);
    check("t4_valid_held", 32'(px.pixel_valid), 32'd1);
    check("t4_data_held", 32'(px.pixel_data), 32'h111111);
    check("t4_idx_held", 32'(px.pixel_idx), 32'd0);
    check("t4_overflow", 32'(err_overflow), 32'd1);
    check("t4_no_xfer", 32'(q_data.size()), 32'd0);
    px.pixel_ready = 1'b1;
    tick();
    check("t4_valid_drop", 32'(px.pixel_valid), 32'd0);
    check("t4_count", 32'(q_data.size()), 32'd1);
    check_head("t4_p0", 0, 24'h111111, 10'd0);
    send_bits(24'h333333, 23, 0);
    check_head("t4_p1", 1, 24'h333333, 10'd2);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("t4_overflow_clr", 32'(err_overflow), 32'd0);
    idle(4900);

    // Partial pixel followed by stream reset.
    q_data.delete();
    q_idx.delete();
    fe_base = fe_cycles;
    send_bits(24'hFFC000, 23, 14);
    idle(4900);
    check("t5_fe", 32'(fe_cycles - fe_base), 32'd1);
    check("t5_partial", 32'(err_partial), 32'd1);
    check("t5_no_pixel", 32'(q_data.size()), 32'd0);
    check("t5_valid", 32'(px.pixel_valid), 32'd0);
    send_bits(24'hABCDEF, 23, 0);
    check("t5_count", 32'(q_data.size()), 32'd1);
    check_head("t5_p0", 0, 24'hABCDEF, 10'd0);

    // Reset in the middle of a HIGH pulse; the rest of that pulse must be ignored.
    q_data.delete();
    q_idx.delete();
    send_bits(24'h5A5A5A, 23, 12);
    sig = 1'b1;
    idle(20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_partial", 32'(err_partial), 32'd0);
    check("t6_rst_valid", 32'(px.pixel_valid), 32'd0);
    idle(T1H_CLKS - 21);
    sig = 1'b0;
    idle(TBIT_CLKS - T1H_CLKS);
    send_bits(24'hC0FFEE, 23, 0);
    check("t6_count", 32'(q_data.size()), 32'd1);
    check_head("t6_p0", 0, 24'hC0FFEE, 10'd0);
    check("t6_errs", 32'({err_overflow, err_partial, err_glitch}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
